// File: rtl/mux_4to1.sv
// Registered 4:1 selector: one of a/b/c/d is captured into y on in_valid,
// giving a clock-aligned, glitch-free selected value with one cycle of latency.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] y_d, y_q;
  logic             vld_d, vld_q;

  always_comb begin
    sel_data = a;
    unique case (sel)
      2'b00: sel_data = a;
      2'b01: sel_data = b;
      2'b10: sel_data = c;
      2'b11: sel_data = d;
    endcase
  end

  // y holds across idle cycles; out_valid marks only freshly captured data
  always_comb begin
    y_d   = in_valid ? sel_data : y_q;
    vld_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y         = y_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: a WIDTH=1 and a WIDTH=8 instance share clock,
// reset, select and in_valid; expected values are written out by hand.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       in_valid;
  logic       a1, b1, c1, d1, y1, v1;
  logic [7:0] a8, b8, c8, d8, y8;
  logic       v8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1)) u_n (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel),
    .in_valid(in_valid), .y(y1), .out_valid(v1)
  );

  mux_4to1 #(.WIDTH(8)) u_w (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel),
    .in_valid(in_valid), .y(y8), .out_valid(v8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after an edge and outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wexp [4];
    wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44;

    // reset with everything driven high
    rst = 1'b1; in_valid = 1'b1; sel = 2'b11;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
    a8 = 8'hff; b8 = 8'hff; c8 = 8'hff; d8 = 8'hff;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_y1", y1, 0); chk("rst_v1", v1, 0);
      chk("rst_y8", y8, 0); chk("rst_v8", v8, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_y1", y1, 0); chk("post_rst_v1", v1, 0);
    chk("post_rst_y8", y8, 0);

    // sequential selection on the 1-bit instance
    a1 = 0; b1 = 0; c1 = 0; d1 = 0; in_valid = 1'b1;
    sel = 2'b00; a1 = 1; tick(); chk("seq_a", y1, 1); chk("seq_a_v", v1, 1);
    sel = 2'b01; b1 = 1; tick(); chk("seq_b", y1, 1); chk("seq_b_v", v1, 1);
    sel = 2'b10; c1 = 1; tick(); chk("seq_c", y1, 1); chk("seq_c_v", v1, 1);
    sel = 2'b11; d1 = 1; tick(); chk("seq_d", y1, 1); chk("seq_d_v", v1, 1);

    // isolation: unselected inputs toggle, y must track b only
    a1 = 1; b1 = 0; c1 = 0; d1 = 0; sel = 2'b01;
    tick(); chk("iso_cap", y1, 0);
    for (int i = 0; i < 4; i++) begin
      a1 = ~a1; c1 = ~c1; d1 = ~d1;
      tick(); chk("iso_y", y1, 0); chk("iso_v", v1, 1);
    end

    // hold: y keeps captured c while in_valid is low
    sel = 2'b10; c1 = 1;
    tick(); chk("hold_cap", y1, 1);
    in_valid = 1'b0; c1 = 0; sel = 2'b00; a1 = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_y", y1, 1); chk("hold_v", v1, 0);
    end
    in_valid = 1'b1;
    tick(); chk("hold_resume", y1, 0); chk("hold_resume_v", v1, 1);

    // wide back-to-back
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick(); chk("wide_y", y8, wexp[i]); chk("wide_v", v8, 1);
    end

    // reset in the middle of a back-to-back stream
    sel = 2'b00; tick(); chk("mid_pre", y8, 8'h11);
    sel = 2'b01; rst = 1'b1;
    tick(); chk("mid_rst_y", y8, 0); chk("mid_rst_v", v8, 0);
    rst = 1'b0; sel = 2'b10;
    tick(); chk("mid_resume_y", y8, 8'h33); chk("mid_resume_v", v8, 1);
    sel = 2'b11;
    tick(); chk("mid_next_y", y8, 8'h44); chk("mid_next_v", v8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
